// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one start/done sequential multiplier among NREQ requesters.
// Optional engine watchdog is compiled in when MULT_TIMEOUT_EN is defined.
module mult_share_ctrl #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*WIDTH-1:0]      req_a,
    input  logic [NREQ*WIDTH-1:0]      req_b,
    output logic [NREQ-1:0]            gnt,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NREQ)-1:0]    resp_id,
    output logic [2*WIDTH-1:0]         resp_product,
    output logic                       resp_err,
    output logic                       mul_reset,
    output logic                       mul_start,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_product,
    input  logic                       mul_done,
    output logic [2:0]                 state_dbg
);
    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mult_share_ctrl: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    // Result handshake: resp_valid rises with resp_id/resp_product/resp_err stable and
    // holds them unchanged until an edge where resp_valid && resp_ready, which retires it.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        CLEAR = 3'd4
    } state_t;

    state_t               state, state_d;
    logic [IDW-1:0]       last, last_d;
    logic [IDW-1:0]       id_d;
    logic [IDW-1:0]       win, cand;
    logic                 found;
    logic [WIDTH-1:0]     a_d, b_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic [NREQ-1:0]      gnt_d;
    logic                 start_d, valid_d, mreset_d;
    logic                 armed, armed_d;

`ifdef MULT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]        wd_cnt, wd_cnt_d;
    logic                 err_q, err_d;
`endif

    // Search order is last+1, last+2, ... wrapping, so the previous winner goes last.
    always_comb begin : rr_pick
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin : next_state
        state_d  = state;
        last_d   = last;
        id_d     = resp_id;
        a_d      = mul_a;
        b_d      = mul_b;
        prod_d   = resp_product;
        gnt_d    = '0;
        start_d  = 1'b0;
        valid_d  = 1'b0;
        mreset_d = 1'b0;
        armed_d  = armed;
`ifdef MULT_TIMEOUT_EN
        wd_cnt_d = wd_cnt;
        err_d    = err_q;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_d    = ISSUE;
                    last_d     = win;
                    id_d       = win;
                    a_d        = req_a[win*WIDTH +: WIDTH];
                    b_d        = req_b[win*WIDTH +: WIDTH];
                    gnt_d[win] = 1'b1;
                    start_d    = 1'b1;
                end
            end
            ISSUE: begin
                state_d  = WAIT;
                armed_d  = 1'b0;
`ifdef MULT_TIMEOUT_EN
                wd_cnt_d = '0;
`endif
            end
            WAIT: begin
                // The engine may still show done from before start was seen, so skip one cycle.
                armed_d = 1'b1;
`ifdef MULT_TIMEOUT_EN
                wd_cnt_d = wd_cnt + 1'b1;
`endif
                if (armed && mul_done) begin
                    state_d = RESP;
                    prod_d  = mul_product;
                    valid_d = 1'b1;
`ifdef MULT_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
`ifdef MULT_TIMEOUT_EN
                else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    prod_d  = '0;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    state_d  = CLEAR;
                    mreset_d = 1'b1;
                end else begin
                    valid_d  = 1'b1;
                end
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last         <= IDW'(NREQ - 1);
            resp_id      <= '0;
            mul_a        <= '0;
            mul_b        <= '0;
            resp_product <= '0;
            gnt          <= '0;
            mul_start    <= 1'b0;
            resp_valid   <= 1'b0;
            mul_reset    <= 1'b1;
            armed        <= 1'b0;
`ifdef MULT_TIMEOUT_EN
            wd_cnt       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            last         <= last_d;
            resp_id      <= id_d;
            mul_a        <= a_d;
            mul_b        <= b_d;
            resp_product <= prod_d;
            gnt          <= gnt_d;
            mul_start    <= start_d;
            resp_valid   <= valid_d;
            mul_reset    <= mreset_d;
            armed        <= armed_d;
`ifdef MULT_TIMEOUT_EN
            wd_cnt       <= wd_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

`ifdef MULT_TIMEOUT_EN
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: behavioural engine, round-robin reference model and response scoreboard.
// Build with MULT_TIMEOUT_EN defined to include the watchdog scenario.
module tb_mult_share_ctrl;
    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;
    localparam int PW      = 2 * WIDTH;
    localparam int EW      = 1 + IDW + PW;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ-1:0]       gnt;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [PW-1:0]         resp_product;
    logic                  resp_err;
    logic                  mul_reset, mul_start;
    logic [WIDTH-1:0]      mul_a, mul_b;
    logic [PW-1:0]         mul_product;
    logic                  mul_done = 1'b0;
    logic [2:0]            state_dbg;

    mult_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_product(resp_product), .resp_err(resp_err), .mul_reset(mul_reset),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .mul_done(mul_done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Behavioural engine: done is a level held until mul_reset; product is junk until done.
    logic [WIDTH-1:0] eng_a = '0, eng_b = '0;
    int               eng_cnt = 0;
    logic             eng_busy = 1'b0;
    logic             eng_never = 1'b0;
    logic [PW-1:0]    eng_junk = '0;

    always @(posedge clk) begin
        eng_junk <= PW'($urandom);
        if (mul_reset === 1'b1) begin
            mul_done <= 1'b0;
            eng_busy <= 1'b0;
        end else if (mul_start === 1'b1) begin
            eng_a    <= mul_a;
            eng_b    <= mul_b;
            eng_cnt  <= $urandom_range(0, 5);
            eng_busy <= 1'b1;
        end else if (eng_busy && !eng_never) begin
            if (eng_cnt == 0) begin
                mul_done <= 1'b1;
                eng_busy <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    assign mul_product = mul_done ? (PW'(eng_a) * PW'(eng_b)) : eng_junk;

    // Requester side
    bit               pend[NREQ];
    logic [WIDTH-1:0] op_a[NREQ], op_b[NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req[i]                  = pend[i];
            req_a[i*WIDTH +: WIDTH] = op_a[i];
            req_b[i*WIDTH +: WIDTH] = op_b[i];
        end
    end

    // Reference model and scoreboard state
    logic [EW-1:0] exp_q[$];
    int            grant_log[$];
    int            model_last;
    int            again_pct, ready_pct, req_pct;
    int            passed, total;
    int            since_hs, since_gnt, done_first;
    logic          prev_valid;
    logic [PW-1:0] last_prod;
    logic [IDW-1:0] last_id;
    logic          last_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int n_pend();
        int c = 0;
        for (int i = 0; i < NREQ; i++) if (pend[i]) c++;
        return c;
    endfunction

    // One clock cycle: observe after the edge, update the model, then drive the next inputs.
    task automatic step();
        logic          hs;
        int            w, j, p;
        logic [EW-1:0] e;
        hs = resp_valid && resp_ready;
        @(posedge clk);
        #1;
        since_hs++;
        since_gnt++;
        if (hs) begin
            since_hs = 0;
            check("clear_pulse", 32'(mul_reset), 1);
            check("valid_drop", 32'(resp_valid), 0);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            check("no_stray_reset", 32'(mul_reset), 0);
            if (prev_valid) check("valid_hold", 32'(resp_valid), 1);
        end
        if (gnt !== '0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                j = (model_last + k) % NREQ;
                if (w < 0 && pend[j]) w = j;
            end
            check("gnt_onehot", 32'(gnt), (w < 0) ? 0 : (32'd1 << w));
            check("gnt_start", 32'(mul_start), 1);
            check("gnt_idle_only", exp_q.size(), 0);
            check("gnt_after_clear", 32'(since_hs >= 2), 1);
            if (w >= 0) begin
                check("op_a", 32'(mul_a), 32'(op_a[w]));
                check("op_b", 32'(mul_b), 32'(op_b[w]));
                p = eng_never ? 0 : int'(op_a[w]) * int'(op_b[w]);
                exp_q.push_back({eng_never, IDW'(w), PW'(p)});
                model_last = w;
                grant_log.push_back(w);
                since_gnt  = 0;
                done_first = -1;
                if ($urandom_range(0, 99) < again_pct) begin
                    op_a[w] = WIDTH'($urandom);
                    op_b[w] = WIDTH'($urandom);
                end else begin
                    pend[w] = 1'b0;
                end
            end
        end else begin
            check("start_idle", 32'(mul_start), 0);
        end
        if (mul_done && done_first < 0) done_first = since_gnt;
        if (resp_valid) begin
            last_prod = resp_product;
            last_id   = resp_id;
            last_err  = resp_err;
            check("one_outstanding", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                check("resp_id", 32'(resp_id), 32'(e[PW +: IDW]));
                check("resp_product", 32'(resp_product), 32'(e[PW-1:0]));
                check("resp_err", 32'(resp_err), 32'(e[EW-1]));
                if (!prev_valid) begin
                    if (e[EW-1]) check("timeout_latency", since_gnt, TIMEOUT + 1);
                    else check("done_latency", since_gnt, ((done_first > 2) ? done_first : 2) + 1);
                end
            end
        end
        prev_valid = resp_valid;
        resp_ready = ($urandom_range(0, 99) < ready_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!pend[i] && $urandom_range(0, 99) < req_pct) begin
                op_a[i] = WIDTH'($urandom);
                op_b[i] = WIDTH'($urandom);
                pend[i] = 1'b1;
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((n_pend() != 0 || exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 32'((n_pend() == 0) && (exp_q.size() == 0)), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_valid"}, 32'(resp_valid), 0);
        check({tag, "_start"}, 32'(mul_start), 0);
        check({tag, "_mul_reset"}, 32'(mul_reset), 1);
        check({tag, "_mul_a"}, 32'(mul_a), 0);
        check({tag, "_mul_b"}, 32'(mul_b), 0);
        check({tag, "_product"}, 32'(resp_product), 0);
        check({tag, "_id"}, 32'(resp_id), 0);
        check({tag, "_err"}, 32'(resp_err), 0);
    endtask

    initial begin
        int n, g0;
        int rr_exp[5];
        logic [PW-1:0] hold;
        rr_exp = '{0, 1, 2, 3, 0};
        passed = 0; total = 0;
        again_pct = 0; ready_pct = 100; req_pct = 0;
        model_last = NREQ - 1;
        since_hs = 100; since_gnt = 0; done_first = -1;
        prev_valid = 1'b0;
        last_prod = '0; last_id = '0; last_err = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; op_a[i] = '0; op_b[i] = '0;
        end
        resp_ready = 1'b0;

        // Clock/reset
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_reset_values("reset");
        reset = 1'b0;
        resp_ready = 1'b1;

        // All requesting: fairness order from reset
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = WIDTH'(17 + 23 * i); op_b[i] = WIDTH'(3 + 41 * i); pend[i] = 1'b1;
        end
        again_pct = 100;
        n = 0;
        while (grant_log.size() < 5 && n < 400) begin step(); n++; end
        again_pct = 0;
        check("rr_count", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) check("rr_order", grant_log[i], rr_exp[i]);
        end
        drain(400);

        // Single request
        op_a[0] = 8'd12; op_b[0] = 8'd10; pend[0] = 1'b1;
        drain(100);
        check("single_product", 32'(last_prod), 120);
        check("single_id", 32'(last_id), 0);

        // Backpressure
        ready_pct = 0;
        op_a[1] = 8'd77; op_b[1] = 8'd201; pend[1] = 1'b1;
        op_a[3] = 8'd9;  op_b[3] = 8'd250; pend[3] = 1'b1;
        n = 0;
        while (!resp_valid && n < 50) begin step(); n++; end
        check("bp_reached", 32'(resp_valid), 1);
        hold = resp_product;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold", 32'(resp_product), 32'(hold));
            check("bp_no_gnt", 32'(gnt), 0);
        end
        ready_pct = 100;
        drain(100);

        // Extremes
        op_a[3] = 8'hFF; op_b[3] = 8'hFF; pend[3] = 1'b1;
        drain(100);
        check("ext_ff", 32'(last_prod), 65025);
        op_a[1] = 8'h00; op_b[1] = 8'hA5; pend[1] = 1'b1;
        drain(100);
        check("ext_zero", 32'(last_prod), 0);

        // Randomized traffic
        req_pct = 15; again_pct = 30; ready_pct = 50;
        for (int i = 0; i < 1500; i++) step();
        req_pct = 0; again_pct = 0; ready_pct = 100;
        drain(400);

        // Reset while waiting on the engine
        eng_never = 1'b1;
        g0 = grant_log.size();
        op_a[1] = 8'd5; op_b[1] = 8'd6; pend[1] = 1'b1;
        n = 0;
        while (grant_log.size() == g0 && n < 20) begin step(); n++; end
        step();
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_values("midreset");
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        model_last = NREQ - 1;
        eng_never  = 1'b0;
        @(posedge clk); #1;
        check("midreset_no_valid", 32'(resp_valid), 0);
        reset = 1'b0;
        prev_valid = 1'b0;
        since_hs = 100;
        resp_ready = 1'b1;
        g0 = grant_log.size();
        op_a[2] = 8'd200; op_b[2] = 8'd3; pend[2] = 1'b1;
        drain(100);
        check("post_reset_grants", grant_log.size(), g0 + 1);
        if (grant_log.size() > g0) check("post_reset_first", grant_log[g0], 2);

`ifdef MULT_TIMEOUT_EN
        // Engine never finishes: watchdog response
        eng_never = 1'b1;
        op_a[0] = 8'd33; op_b[0] = 8'd44; pend[0] = 1'b1;
        drain(200);
        check("timeout_err", 32'(last_err), 1);
        check("timeout_product", 32'(last_prod), 0);
        eng_never = 1'b0;
        op_a[2] = 8'd11; op_b[2] = 8'd13; pend[2] = 1'b1;
        drain(100);
        check("after_timeout_err", 32'(last_err), 0);
        check("after_timeout_product", 32'(last_prod), 143);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
